// File: rtl/snax_acc_csr_responder.sv
// snax_acc_csr_responder: CSR responder on the Snitch accelerator offload port.
// Decodes offloaded CSRRW/CSRRS, holds config regs, starts the datapath, queues responses.
module snax_acc_csr_responder #(
  parameter logic [11:0] CsrBase  = 12'h3c0,
  parameter int unsigned NumRegs  = 8,
  parameter int unsigned RspDepth = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        acc_qvalid_i,
  output logic                        acc_qready_o,
  input  logic [4:0]                  acc_qid_i,
  input  logic [31:0]                 acc_qdata_op_i,
  input  logic [31:0]                 acc_qdata_arga_i,
  output logic                        acc_pvalid_o,
  input  logic                        acc_pready_i,
  output logic [4:0]                  acc_pid_o,
  output logic [31:0]                 acc_pdata_o,
  output logic                        acc_perror_o,
  output logic [(NumRegs-2)*32-1:0]   csr_cfg_o,
  output logic                        start_o,
  input  logic                        busy_i,
  input  logic                        done_i
);

  localparam int unsigned NCfg = NumRegs - 2;
  localparam int unsigned PW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int unsigned CW = $clog2(RspDepth + 1);
  localparam int unsigned EW = 38;

  logic [NCfg-1:0][31:0] r_cfg;
  logic                  r_drop;
  logic [15:0]           r_done_cnt;
  logic                  r_start;
  logic [EW-1:0]         r_mem [RspDepth];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_cnt;

  logic [2:0]    w_funct3;
  logic [11:0]   w_idx;
  logic          w_inrange;
  logic          w_is_wr;
  logic          w_is_rd;
  logic          w_accept;
  logic          w_wr_ok;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_rdata;
  logic          w_rerr;
  logic [EW-1:0] w_head;
  logic          w_unused;

  assign w_funct3  = acc_qdata_op_i[14:12];
  assign w_idx     = acc_qdata_op_i[31:20] - CsrBase;
  assign w_inrange = (w_idx < 12'(NumRegs));
  assign w_is_wr   = (w_funct3 == 3'b001);
  assign w_is_rd   = (w_funct3 == 3'b010);
  assign w_unused  = ^{acc_qdata_op_i[19:15], acc_qdata_op_i[11:0]};

  assign acc_qready_o = (r_cnt < CW'(RspDepth));
  assign w_accept     = acc_qvalid_i & acc_qready_o;
  assign w_wr_ok      = w_accept & w_is_wr & w_inrange;
  assign w_push       = w_accept & ~w_is_wr;
  assign w_pop        = acc_pvalid_o & acc_pready_i;

  always_comb begin
    w_rdata = '0;
    w_rerr  = 1'b1;
    if (w_is_rd && w_inrange) begin
      w_rerr = 1'b0;
      if (w_idx == 12'd0) begin
        w_rdata = {30'b0, r_drop, 1'b0};
      end else if (w_idx == 12'd1) begin
        w_rdata = {busy_i, 15'b0, r_done_cnt};
      end else begin
        for (int i = 0; i < int'(NCfg); i++) begin
          if (w_idx == 12'(i + 2)) w_rdata = r_cfg[i];
        end
      end
    end
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(RspDepth - 1)) return '0;
    return p + 1'b1;
  endfunction

  // CTRL: bit0 requests a start, bit1 clears the sticky drop flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cfg      <= '0;
      r_drop     <= 1'b0;
      r_start    <= 1'b0;
      r_done_cnt <= '0;
    end else begin
      r_start <= w_wr_ok && (w_idx == 12'd0) &&
                 acc_qdata_arga_i[0] && !busy_i;
      if (w_wr_ok && (w_idx == 12'd0)) begin
        if (acc_qdata_arga_i[1]) begin
          r_drop <= 1'b0;
        end else if (acc_qdata_arga_i[0] && busy_i) begin
          r_drop <= 1'b1;
        end
      end
      for (int i = 0; i < int'(NCfg); i++) begin
        if (w_wr_ok && (w_idx == 12'(i + 2))) begin
          r_cfg[i] <= acc_qdata_arga_i;
        end
      end
      if (done_i) r_done_cnt <= r_done_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!w_push && w_pop) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= {acc_qid_i, w_rdata, w_rerr};
  end

  assign w_head       = r_mem[r_rptr];
  assign acc_pvalid_o = (r_cnt != '0);
  assign acc_pid_o    = acc_pvalid_o ? w_head[37:33] : '0;
  assign acc_pdata_o  = acc_pvalid_o ? w_head[32:1] : '0;
  assign acc_perror_o = acc_pvalid_o ? w_head[0] : 1'b0;
  assign csr_cfg_o    = r_cfg;
  assign start_o      = r_start;

endmodule
